// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: buffered 8N1 UART transmitter.
//
// The host writes bytes into a small circular FIFO (one byte per rising
// edge of `write`); a transmit FSM pops them one at a time and serialises
// each as start bit, 8 data bits LSB first, stop bit on `txOUT`. A built-in
// divider produces a 16x oversample tick; one bit time is 16*CLK_DIV clocks.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   write      write request; only its rising edge enqueues a byte
//   datain     byte captured on the write rising-edge cycle
//   txOUT      serial output, idle high, driven from a register
//   tx_ready   FIFO can accept a byte (~buf_full)
//   buf_empty  FIFO holds no bytes
//   buf_full   FIFO holds 2^FIFO_BITS bytes
//   busy       a frame is on the line (FSM not IDLE)
//   count      number of bytes in the FIFO
module uart_tx_buffered #(
    parameter int CLK_DIV   = 8,
    parameter int FIFO_BITS = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 write,
    input  logic [7:0]           datain,
    output logic                 txOUT,
    output logic                 tx_ready,
    output logic                 buf_empty,
    output logic                 buf_full,
    output logic                 busy,
    output logic [FIFO_BITS:0]   count
);

    localparam int                 DEPTH    = 1 << FIFO_BITS;
    localparam logic [FIFO_BITS:0] FULL_CNT = (FIFO_BITS + 1)'(DEPTH);
    localparam logic [7:0]         DIV_MAX  = 8'(CLK_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // FIFO storage and control
    logic [7:0]           r_mem [DEPTH];
    logic [FIFO_BITS-1:0] r_wptr;
    logic [FIFO_BITS-1:0] r_rptr;
    logic [FIFO_BITS:0]   r_count;
    logic                 r_empty;
    logic                 r_full;
    logic                 r_write_d;

    // Transmit FSM and baud divider
    state_t               r_state;
    logic [7:0]           r_sh;
    logic [2:0]           r_idx;
    logic [7:0]           r_div;
    logic [3:0]           r_sub;
    logic                 r_tx;

    logic                 w_push;
    logic                 w_wr;
    logic                 w_pop;
    logic [FIFO_BITS:0]   w_count_nxt;
    logic                 w_tick;
    logic                 w_bit_end;
    state_t               w_state_nxt;
    logic [7:0]           w_sh_nxt;
    logic [2:0]           w_idx_nxt;
    logic                 w_tx_nxt;

    assign w_push    = write & ~r_write_d;
    // A push into a full FIFO is accepted only when a pop frees the slot
    // in the same cycle; otherwise the byte is dropped.
    assign w_wr      = w_push & (~r_full | w_pop);
    assign w_tick    = (r_div == DIV_MAX);
    assign w_bit_end = w_tick & (r_sub == 4'd15);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_write_d <= 1'b0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_empty   <= 1'b1;
            r_full    <= 1'b0;
        end else begin
            r_write_d <= write;
            if (w_wr)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == FULL_CNT);
        end
    end

    // When full, wptr equals rptr: the head is read combinationally before
    // this edge overwrites the slot, so push+pop on a full FIFO is safe.
    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wptr] <= datain;
    end

    // Divider is held at zero in IDLE, so counting restarts exactly when a
    // byte is loaded and the start bit lasts a full 16*CLK_DIV cycles.
    always_ff @(posedge clk) begin
        if (reset || r_state == S_IDLE) begin
            r_div <= '0;
            r_sub <= '0;
        end else if (w_tick) begin
            r_div <= '0;
            r_sub <= r_sub + 1'b1;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    always_ff @(posedge clk) begin
        r_sh <= w_sh_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sh_nxt    = r_sh;
        w_idx_nxt   = r_idx;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_empty) begin
                    w_pop       = 1'b1;
                    w_sh_nxt    = r_mem[r_rptr];
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_sh_nxt  = {1'b0, r_sh[7:1]};
                    w_idx_nxt = r_idx + 1'b1;
                    if (r_idx == 3'd7)
                        w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_end)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Line level is computed from the next state so the register
        // output changes on the same edge as the state.
        case (w_state_nxt)
            S_START: w_tx_nxt = 1'b0;
            S_DATA:  w_tx_nxt = w_sh_nxt[0];
            default: w_tx_nxt = 1'b1;
        endcase
    end

    assign txOUT     = r_tx;
    assign busy      = (r_state != S_IDLE);
    assign buf_empty = r_empty;
    assign buf_full  = r_full;
    assign tx_ready  = ~r_full;
    assign count     = r_count;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Testbench for uart_tx_buffered: one instance with CLK_DIV=2 checked by a
// frame-decoding monitor and a byte scoreboard, one with CLK_DIV=1 checked
// for exact line timing.
module tb_uart_tx_buffered;

    localparam int BIT = 32;   // 16 * CLK_DIV for the main instance

    logic       clk = 1'b0;
    logic       reset;
    logic       write, w1;
    logic [7:0] datain, d1;
    logic       txOUT, tx_ready, buf_empty, buf_full, busy;
    logic [2:0] count;
    logic       tx1, rdy1, emp1, full1, busy1;
    logic [2:0] cnt1;

    uart_tx_buffered #(.CLK_DIV(2), .FIFO_BITS(2)) u_dut (
        .clk(clk), .reset(reset), .write(write), .datain(datain),
        .txOUT(txOUT), .tx_ready(tx_ready), .buf_empty(buf_empty),
        .buf_full(buf_full), .busy(busy), .count(count)
    );

    uart_tx_buffered #(.CLK_DIV(1), .FIFO_BITS(2)) u_dut1 (
        .clk(clk), .reset(reset), .write(w1), .datain(d1),
        .txOUT(tx1), .tx_ready(rdy1), .buf_empty(emp1),
        .buf_full(full1), .busy(busy1), .count(cnt1)
    );

    always #5 clk = ~clk;

    int cyc     = 0;
    int rst_cnt = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) rst_cnt <= rst_cnt + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    bit         rx_ok_q[$];
    int         rx_st_q[$];

    // Frame monitor: samples each bit at its midpoint; frames interrupted
    // by reset are discarded.
    logic [9:0] mon_f;
    int         mon_st, mon_rst;
    always begin
        @(negedge clk);
        if (txOUT === 1'b0) begin
            mon_st  = cyc;
            mon_rst = rst_cnt;
            mon_f   = '1;
            for (int c = 0; c <= BIT / 2 + 9 * BIT; c++) begin
                if (c > 0) @(negedge clk);
                if (c >= BIT / 2 && ((c - BIT / 2) % BIT) == 0)
                    mon_f[(c - BIT / 2) / BIT] = txOUT;
            end
            if (rst_cnt == mon_rst) begin
                rx_q.push_back(mon_f[8:1]);
                rx_ok_q.push_back(mon_f[0] == 1'b0 && mon_f[9] == 1'b1);
                rx_st_q.push_back(mon_st);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [7:0] b);
        write  = 1'b1;
        datain = b;
        tick(1);
        write  = 1'b0;
        tick(1);
    endtask

    task automatic wait_rx(input int n, input int budget, output bit ok);
        int c = 0;
        while (rx_q.size() < n && c < budget) begin
            tick(1);
            c++;
        end
        ok = (rx_q.size() >= n);
    endtask

    task automatic test_reset;
        reset = 1'b1; write = 1'b0; datain = '0; w1 = 1'b0; d1 = '0;
        tick(3);
        n_cmp++; if (txOUT !== 1'b1) begin n_bad++; $display("FAIL reset_txOUT: got %b want 1", txOUT); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (buf_empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b want 1", buf_empty); end
        n_cmp++; if (buf_full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", buf_full); end
        n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", tx_ready); end
        n_cmp++; if (tx1 !== 1'b1) begin n_bad++; $display("FAIL reset_tx1: got %b want 1", tx1); end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_single;
        logic [7:0] p = 8'h55;
        logic       e;
        int         bad;
        bit         ok;
        exp_q.push_back(p);
        write = 1'b1; datain = p;
        tick(1);
        write = 1'b0;
        n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL single_count_after_push: got %0d want 1", count); end
        n_cmp++; if (txOUT !== 1'b1) begin n_bad++; $display("FAIL single_tx_before_start: got %b want 1", txOUT); end
        tick(1);
        for (int k = 0; k < 10; k++) begin
            e   = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : p[k - 1];
            bad = 0;
            for (int i = 0; i < BIT; i++) begin
                if (txOUT !== e || busy !== 1'b1) bad++;
                tick(1);
            end
            n_cmp++;
            if (bad != 0) begin
                n_bad++;
                $display("FAIL single_bit%0d: got %0d wrong cycles want 0 (level %b, busy 1)", k, bad, e);
            end
        end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_end: got %b want 0", busy); end
        n_cmp++; if (txOUT !== 1'b1) begin n_bad++; $display("FAIL single_tx_end: got %b want 1", txOUT); end
        wait_rx(1, 50, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_rx: got %0d frames want 1", rx_q.size()); end
        if (ok) begin
            logic [7:0] g, x;
            bit fo;
            g = rx_q.pop_front(); fo = rx_ok_q.pop_front(); void'(rx_st_q.pop_front());
            x = exp_q.pop_front();
            n_cmp++; if (g !== x) begin n_bad++; $display("FAIL single_byte: got %h want %h", g, x); end
            n_cmp++; if (!fo) begin n_bad++; $display("FAIL single_framing: got bad want good"); end
        end
        exp_q.delete();
        tick(10);
    endtask

    task automatic test_burst;
        bit ok;
        int prev_st;
        for (int i = 1; i <= 5; i++) begin
            exp_q.push_back(8'(i));
            pulse(8'(i));
        end
        // First byte is already on the line, so four fill the FIFO and
        // this one has nowhere to go.
        pulse(8'hAA);
        n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL burst_count: got %0d want 4", count); end
        n_cmp++; if (buf_full !== 1'b1) begin n_bad++; $display("FAIL burst_full: got %b want 1", buf_full); end
        n_cmp++; if (tx_ready !== 1'b0) begin n_bad++; $display("FAIL burst_ready: got %b want 0", tx_ready); end
        n_cmp++; if (buf_empty !== 1'b0) begin n_bad++; $display("FAIL burst_empty: got %b want 0", buf_empty); end
        wait_rx(5, 5 * 330 + 200, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL burst_rx: got %0d frames want 5", rx_q.size()); end
        prev_st = 0;
        for (int i = 0; i < 5; i++) begin
            logic [7:0] g, x;
            bit fo;
            int st;
            if (rx_q.size() == 0) break;
            g = rx_q.pop_front(); fo = rx_ok_q.pop_front(); st = rx_st_q.pop_front();
            x = exp_q.pop_front();
            n_cmp++; if (g !== x) begin n_bad++; $display("FAIL burst_byte%0d: got %h want %h", i, g, x); end
            n_cmp++; if (!fo) begin n_bad++; $display("FAIL burst_framing%0d: got bad want good", i); end
            if (i > 0) begin
                n_cmp++;
                if (st - prev_st != 10 * BIT + 1) begin
                    n_bad++;
                    $display("FAIL burst_spacing%0d: got %0d want %0d", i, st - prev_st, 10 * BIT + 1);
                end
            end
            prev_st = st;
        end
        tick(400);
        n_cmp++; if (rx_q.size() != 0) begin n_bad++; $display("FAIL burst_extra_frames: got %0d want 0", rx_q.size()); end
        rx_q.delete(); rx_ok_q.delete(); rx_st_q.delete(); exp_q.delete();
    endtask

    task automatic test_hold;
        int maxc = 0;
        bit ok;
        exp_q.push_back(8'h3C);
        write = 1'b1; datain = 8'h3C;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (int'(count) > maxc) maxc = int'(count);
        end
        write = 1'b0;
        wait_rx(1, 400, ok);
        tick(400);
        n_cmp++; if (maxc != 1) begin n_bad++; $display("FAIL hold_max_count: got %0d want 1", maxc); end
        n_cmp++; if (rx_q.size() != 1) begin n_bad++; $display("FAIL hold_frames: got %0d want 1", rx_q.size()); end
        if (rx_q.size() > 0) begin
            logic [7:0] g, x;
            g = rx_q.pop_front(); void'(rx_ok_q.pop_front()); void'(rx_st_q.pop_front());
            x = exp_q.pop_front();
            n_cmp++; if (g !== x) begin n_bad++; $display("FAIL hold_byte: got %h want %h", g, x); end
        end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL hold_busy: got %b want 0", busy); end
        rx_q.delete(); rx_ok_q.delete(); rx_st_q.delete(); exp_q.delete();
    endtask

    task automatic test_full_pushpop;
        int c = 0;
        bit ok;
        for (int i = 1; i <= 5; i++) begin
            exp_q.push_back(8'(i));
            pulse(8'(i));
        end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL fpp_busy_pre: got %b want 1", busy); end
        // The single IDLE cycle between frames is the pop cycle; write
        // rises so its edge is sampled on that same clock.
        while (busy !== 1'b0 && c < 400) begin
            tick(1);
            c++;
        end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL fpp_idle_seen: got busy %b want 0", busy); end
        exp_q.push_back(8'h06);
        write = 1'b1; datain = 8'h06;
        tick(1);
        write = 1'b0;
        n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL fpp_count: got %0d want 4", count); end
        n_cmp++; if (buf_full !== 1'b1) begin n_bad++; $display("FAIL fpp_full: got %b want 1", buf_full); end
        wait_rx(6, 6 * 330 + 200, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL fpp_rx: got %0d frames want 6", rx_q.size()); end
        for (int i = 0; i < 6; i++) begin
            logic [7:0] g, x;
            if (rx_q.size() == 0) break;
            g = rx_q.pop_front(); void'(rx_ok_q.pop_front()); void'(rx_st_q.pop_front());
            x = exp_q.pop_front();
            n_cmp++; if (g !== x) begin n_bad++; $display("FAIL fpp_byte%0d: got %h want %h", i, g, x); end
        end
        tick(20);
        rx_q.delete(); rx_ok_q.delete(); rx_st_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid;
        int bad = 0;
        bit ok;
        pulse(8'hF0);
        pulse(8'hA1);
        pulse(8'hA2);
        tick(100);   // well inside the data bits of 0xF0
        n_cmp++; if (busy !== 1'b1 || count !== 3'd2) begin
            n_bad++; $display("FAIL rmid_pre: got busy %b count %0d want busy 1 count 2", busy, count);
        end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        n_cmp++; if (txOUT !== 1'b1) begin n_bad++; $display("FAIL rmid_tx: got %b want 1", txOUT); end
        n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL rmid_count: got %0d want 0", count); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
        n_cmp++; if (buf_empty !== 1'b1) begin n_bad++; $display("FAIL rmid_empty: got %b want 1", buf_empty); end
        for (int i = 0; i < 800; i++) begin
            tick(1);
            if (txOUT !== 1'b1 || busy !== 1'b0) bad++;
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL rmid_quiet: got %0d active cycles want 0", bad); end
        n_cmp++; if (rx_q.size() != 0) begin n_bad++; $display("FAIL rmid_frames: got %0d want 0", rx_q.size()); end
        rx_q.delete(); rx_ok_q.delete(); rx_st_q.delete();
        exp_q.push_back(8'h5A);
        pulse(8'h5A);
        wait_rx(1, 400, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rmid_recover_rx: got %0d frames want 1", rx_q.size()); end
        if (ok) begin
            logic [7:0] g, x;
            g = rx_q.pop_front(); void'(rx_ok_q.pop_front()); void'(rx_st_q.pop_front());
            x = exp_q.pop_front();
            n_cmp++; if (g !== x) begin n_bad++; $display("FAIL rmid_recover_byte: got %h want %h", g, x); end
        end
        tick(40);
        rx_q.delete(); rx_ok_q.delete(); rx_st_q.delete(); exp_q.delete();
    endtask

    task automatic test_clkdiv1;
        int c = 0, lowc = 0, hic = 0;
        w1 = 1'b1; d1 = 8'h00;
        tick(1);
        w1 = 1'b0;
        while (tx1 !== 1'b0 && c < 10) begin
            tick(1);
            c++;
        end
        while (tx1 === 1'b0 && lowc < 400) begin
            lowc++;
            tick(1);
        end
        n_cmp++; if (lowc != 144) begin n_bad++; $display("FAIL div1_low: got %0d cycles want 144", lowc); end
        while (tx1 === 1'b1 && busy1 === 1'b1 && hic < 100) begin
            hic++;
            tick(1);
        end
        n_cmp++; if (hic != 16) begin n_bad++; $display("FAIL div1_stop: got %0d cycles want 16", hic); end
        n_cmp++; if (busy1 !== 1'b0 || tx1 !== 1'b1) begin
            n_bad++; $display("FAIL div1_idle: got busy %b tx %b want busy 0 tx 1", busy1, tx1);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_hold();
        test_full_pushpop();
        test_reset_mid();
        test_clkdiv1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- Buffered UART transmit path: the transmit counterpart to our buffered UART receive path.
- Accepts bytes from the CPU/host side into a small FIFO and serialises them as 8N1 frames on txOUT.
- Contains its own 16x-oversample baud tick divider and its own transmit FSM.
- Lets software queue a burst of bytes without polling between characters.

Parameters:
- CLK_DIV, 8, clk cycles per oversample tick; one bit time = 16*CLK_DIV clk cycles. Legal range 1..255.
- FIFO_BITS, 2, log2 of FIFO depth; depth = 2^FIFO_BITS entries.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- write  input  1  write request; only the rising edge (write=1 this cycle, write=0 previous cycle) enqueues a byte
- datain  input  8  byte captured on the write rising-edge cycle
- txOUT  output  1  serial line; idle high
- tx_ready  output  1  equals ~buf_full
- buf_empty  output  1  FIFO holds no bytes
- buf_full  output  1  FIFO holds 2^FIFO_BITS bytes
- busy  output  1  high while a frame is on the line (FSM not IDLE)
- count  output  FIFO_BITS+1  number of bytes in FIFO

Behaviour:
- Reset values (synchronous, applied on the clk edge with reset=1):
  - txOUT=1, busy=0, buf_empty=1, buf_full=0, count=0, tx_ready=1.
  - FIFO pointers, edge register, divider and FSM all cleared to IDLE.
  - Reset mid-frame aborts the frame: txOUT=1 on the next cycle and the FIFO contents are discarded.
- Write edge detect:
  - Registered write_d; push = write & ~write_d.
  - Holding write high enqueues exactly one byte.
- FIFO:
  - Circular buffer with FIFO_BITS-wide pointers that wrap modulo depth.
  - Push when full: byte dropped, no state change.
  - Push and pop in the same cycle when full: both happen, count unchanged, and the new byte is stored.
  - Push and pop in the same cycle when neither full nor empty: count unchanged.
  - count, buf_empty and buf_full are registered and valid on the cycle after the push or pop.
- Baud divider:
  - div_cnt counts 0..CLK_DIV-1; tick=1 for one clk when div_cnt=CLK_DIV-1.
  - sub_cnt (4 bits) advances on each tick; a bit ends on the tick where sub_cnt=15.
  - Both counters are cleared when a byte is loaded, so the start bit is exactly 16*CLK_DIV cycles long.
- FSM states:
  - IDLE: txOUT=1. If ~buf_empty: pop the FIFO head into shift register sh, go to START.
  - START: txOUT=0 for one bit time, then go to DATA with bit index=0.
  - DATA: txOUT=sh[0], LSB first. At the end of each bit, shift sh right and increment the index; after bit 7 go to STOP.
  - STOP: txOUT=1 for one bit time, then go to IDLE.
- Back-to-back frames: with the FIFO non-empty at STOP end, IDLE lasts exactly 1 cycle before the next START. The gap between frames is therefore stop bit + 1 clk.
- Latency: push sampled in cycle n → FIFO written at end of n → FSM pops in n+1 → txOUT=0 from cycle n+2.
- Frame length: 10 bit times = 160*CLK_DIV cycles.
- txOUT is driven from a register (glitch-free).
- Pop happens only in IDLE; at most one pop per frame.

Test Plan:
1. CLK_DIV=2, reset held 3 cycles → txOUT=1, buf_empty=1, count=0, busy=0. Then write edge with datain=0x55 → txOUT low 2 cycles after the edge, then bits 1,0,1,0,1,0,1,0 (LSB first), each 32 cycles, then stop bit high 32 cycles. busy is high for 320 cycles.
2. FIFO_BITS=2, CLK_DIV=2: 5 write pulses (0x01..0x05) in consecutive pulses while idle → first byte popped immediately, remaining 4 fill the FIFO, buf_full=1, tx_ready=0. A 6th pulse 0xAA is dropped. Line shows 0x01..0x05 back-to-back with a 1-clk idle gap between frames, and no 0xAA.
3. write held high for 100 cycles with datain=0x3C → exactly one frame of 0x3C; count never exceeds 1.
4. FIFO full, write edge in the same cycle the FSM pops → count stays 4 and the new byte is transmitted last in order.
5. Reset asserted mid-DATA of 0xF0 with 2 bytes queued → next cycle txOUT=1, count=0, busy=0. No further frames until a new write.
6. CLK_DIV=1: write 0x00 → low for 144 cycles (start + 8 data bits), then high for 16 cycles.
